// File: rtl/msrh_ldq_issue_sched.sv
// LDQ issue scheduler: tracks entry validity and relative age, and picks the
// oldest ready entry per LSU pipe (pipe 0 first; later pipes skip entries
// already taken). The pick to the entries is combinational and the issue to
// each pipe is registered one cycle later.
module msrh_ldq_issue_sched #(
  parameter  int LDQ_SIZE     = 16,
  parameter  int LSU_INST_NUM = 2,
  localparam int CW           = $clog2(LDQ_SIZE+1)
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic [LDQ_SIZE-1:0]              i_alloc_oh,
  input  logic [LDQ_SIZE-1:0]              i_release_oh,
  input  logic [LDQ_SIZE-1:0]              i_entry_ready,
  input  logic [LDQ_SIZE*LSU_INST_NUM-1:0] i_entry_pipe_sel,
  input  logic [LSU_INST_NUM-1:0]          i_pipe_stall,
  output logic [LDQ_SIZE-1:0]              o_entry_picked,
  output logic [LSU_INST_NUM-1:0]          o_issue_valid,
  output logic [LSU_INST_NUM*LDQ_SIZE-1:0] o_issue_idx_oh,
  output logic [CW-1:0]                    o_valid_cnt,
  output logic                             o_full
);

  logic [LDQ_SIZE-1:0]                    valid_q, valid_d;
  // older_q[i][j] = 1 means entry i is older than entry j
  logic [LDQ_SIZE-1:0][LDQ_SIZE-1:0]      older_q, older_d;
  logic [LDQ_SIZE-1:0][LDQ_SIZE-1:0]      older_col;
  logic [LSU_INST_NUM-1:0][LDQ_SIZE-1:0]  cand, pick;
  logic [LDQ_SIZE-1:0]                    taken;
  logic [LSU_INST_NUM-1:0]                issue_valid_q, issue_valid_d;
  logic [LSU_INST_NUM-1:0][LDQ_SIZE-1:0]  issue_idx_q, issue_idx_d;
  logic [CW-1:0]                          cnt_q, cnt_d, n_alloc, n_rel;
  logic [LDQ_SIZE-1:0]                    surv;

  // transpose so "who is older than i" is a contiguous vector
  always_comb begin
    older_col = '0;
    for (int i = 0; i < LDQ_SIZE; i++)
      for (int k = 0; k < LDQ_SIZE; k++)
        older_col[i][k] = older_q[k][i];
  end

  // per-pipe oldest-candidate pick, earlier pipes have priority
  always_comb begin
    cand  = '0;
    pick  = '0;
    taken = '0;
    for (int p = 0; p < LSU_INST_NUM; p++) begin
      for (int e = 0; e < LDQ_SIZE; e++)
        cand[p][e] = i_entry_ready[e] & valid_q[e] & ~taken[e] &
                     i_entry_pipe_sel[e*LSU_INST_NUM+p];
      for (int i = 0; i < LDQ_SIZE; i++)
        pick[p][i] = cand[p][i] & ~(|(cand[p] & older_col[i])) & ~i_pipe_stall[p];
      taken = taken | pick[p];
    end
  end

  // next valid vector and age matrix; a released-and-reallocated entry
  // ends up valid and youngest
  always_comb begin
    surv    = valid_q & ~i_release_oh;
    valid_d = surv | i_alloc_oh;
    older_d = '0;
    for (int i = 0; i < LDQ_SIZE; i++)
      for (int j = 0; j < LDQ_SIZE; j++) begin
        if (i == j)                            older_d[i][j] = 1'b0;
        else if (i_alloc_oh[i] && i_alloc_oh[j]) older_d[i][j] = (i < j);
        else if (i_alloc_oh[j])                older_d[i][j] = surv[i];
        else if (i_alloc_oh[i])                older_d[i][j] = 1'b0;
        else if (!surv[i] || !surv[j])         older_d[i][j] = 1'b0;
        else                                   older_d[i][j] = older_q[i][j];
      end
  end

  // occupancy count and registered issue
  always_comb begin
    n_alloc = '0;
    n_rel   = '0;
    for (int e = 0; e < LDQ_SIZE; e++) begin
      n_alloc = n_alloc + CW'(i_alloc_oh[e]);
      n_rel   = n_rel + CW'(i_release_oh[e]);
    end
    cnt_d = cnt_q + n_alloc - n_rel;
    issue_idx_d = pick;
    for (int p = 0; p < LSU_INST_NUM; p++) issue_valid_d[p] = |pick[p];
  end

  // state registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid_q       <= '0;
      older_q       <= '0;
      issue_valid_q <= '0;
      issue_idx_q   <= '0;
      cnt_q         <= '0;
    end else begin
      valid_q       <= valid_d;
      older_q       <= older_d;
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
      cnt_q         <= cnt_d;
    end
  end

  assign o_entry_picked = taken;
  assign o_issue_valid  = issue_valid_q;
  assign o_issue_idx_oh = issue_idx_q;
  assign o_valid_cnt    = cnt_q;
  assign o_full         = (cnt_q == CW'(LDQ_SIZE));

`ifndef SYNTHESIS
  // protocol checks on the dispatch/finish stream and pick sanity
  always @(posedge i_clk) begin
    if (i_reset_n) begin
      if (|(i_alloc_oh & valid_q & ~i_release_oh))
        $fatal(1, "ldq_issue_sched: allocation of an already valid entry");
      if (|(i_release_oh & ~valid_q))
        $fatal(1, "ldq_issue_sched: release of an invalid entry");
      for (int p = 0; p < LSU_INST_NUM; p++)
        if (!$onehot0(pick[p]))
          $fatal(1, "ldq_issue_sched: pick is not one-hot");
    end
  end
`endif

endmodule

// File: tb/tb_msrh_ldq_issue_sched.sv
// Bench for msrh_ldq_issue_sched: directed vector table, a reset-in-flight
// sequence and constrained-random traffic against an age-stamp model.
module tb_msrh_ldq_issue_sched;
  localparam int L  = 16;
  localparam int P  = 2;
  localparam int CW = $clog2(L+1);
  localparam logic [31:0] SEL0 = 32'h5555_5555;
  localparam logic [31:0] SELB = 32'hFFFF_FFFF;

  logic              i_clk = 1'b0;
  logic              i_reset_n;
  logic [L-1:0]      i_alloc_oh, i_release_oh, i_entry_ready;
  logic [L*P-1:0]    i_entry_pipe_sel;
  logic [P-1:0]      i_pipe_stall;
  logic [L-1:0]      o_entry_picked;
  logic [P-1:0]      o_issue_valid;
  logic [P*L-1:0]    o_issue_idx_oh;
  logic [CW-1:0]     o_valid_cnt;
  logic              o_full;

  msrh_ldq_issue_sched #(.LDQ_SIZE(L), .LSU_INST_NUM(P)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_alloc_oh(i_alloc_oh), .i_release_oh(i_release_oh),
    .i_entry_ready(i_entry_ready), .i_entry_pipe_sel(i_entry_pipe_sel),
    .i_pipe_stall(i_pipe_stall), .o_entry_picked(o_entry_picked),
    .o_issue_valid(o_issue_valid), .o_issue_idx_oh(o_issue_idx_oh),
    .o_valid_cnt(o_valid_cnt), .o_full(o_full));

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model: each valid entry carries an allocation stamp; smaller = older
  bit          mv[L];
  int unsigned mst[L];
  int unsigned stamp_ctr = 0;
  logic [P-1:0][L-1:0] m_pick, m_idx;
  logic [P-1:0]        m_iv;

  function automatic int m_cnt();
    int c = 0;
    for (int e = 0; e < L; e++) c += int'(mv[e]);
    return c;
  endfunction

  function automatic logic [L-1:0] m_valid_mask();
    logic [L-1:0] m = '0;
    for (int e = 0; e < L; e++) m[e] = mv[e];
    return m;
  endfunction

  task automatic m_reset();
    for (int e = 0; e < L; e++) mv[e] = 0;
    m_iv = '0; m_idx = '0;
  endtask

  task automatic m_compute_pick();
    logic [L-1:0] tk = '0;
    m_pick = '0;
    for (int p = 0; p < P; p++) begin
      int best = -1;
      if (!i_pipe_stall[p])
        for (int e = 0; e < L; e++)
          if (mv[e] && i_entry_ready[e] && i_entry_pipe_sel[e*P+p] && !tk[e])
            if (best < 0 || mst[e] < mst[best]) best = e;
      if (best >= 0) begin m_pick[p][best] = 1'b1; tk[best] = 1'b1; end
    end
  endtask

  task automatic m_commit();
    for (int p = 0; p < P; p++) m_iv[p] = |m_pick[p];
    m_idx = m_pick;
    for (int e = 0; e < L; e++) if (i_release_oh[e]) mv[e] = 0;
    for (int e = 0; e < L; e++)
      if (i_alloc_oh[e]) begin mv[e] = 1; mst[e] = stamp_ctr; stamp_ctr++; end
  endtask

  logic [L-1:0] last_pick;

  // one cycle: drive at posedge+1, check pick mid-cycle, check registers after edge
  task automatic tick(input logic [L-1:0] a, r, rd, input logic [L*P-1:0] s,
                      input logic [P-1:0] st);
    logic [P-1:0][L-1:0] mp;
    i_alloc_oh = a; i_release_oh = r; i_entry_ready = rd;
    i_entry_pipe_sel = s; i_pipe_stall = st;
    m_compute_pick();
    mp = m_pick;
    @(negedge i_clk);
    last_pick = o_entry_picked;
    chk("pick_model", 64'(o_entry_picked), 64'(mp[0] | mp[1]));
    @(posedge i_clk);
    m_commit();
    #1;
    chk("iv_model",  64'(o_issue_valid), 64'(m_iv));
    chk("idx_model", 64'(o_issue_idx_oh), 64'(m_idx));
    chk("cnt_model", 64'(o_valid_cnt), 64'(m_cnt()));
    chk("full_model", 64'(o_full), 64'(m_cnt() == L));
  endtask

  typedef struct {
    logic [L-1:0]   a, r, rd;
    logic [L*P-1:0] s;
    logic [P-1:0]   st;
    logic [L-1:0]   e_pick;
    logic [P-1:0]   e_iv;
    logic [L-1:0]   e_idx0, e_idx1;
    logic [CW-1:0]  e_cnt;
    logic           e_full;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [L-1:0] a, r, rd, input logic [L*P-1:0] s,
                     input logic [P-1:0] st, input logic [L-1:0] ep,
                     input logic [P-1:0] eiv, input logic [L-1:0] ei0, ei1,
                     input logic [CW-1:0] ec, input logic ef);
    vec_t v;
    v.a = a; v.r = r; v.rd = rd; v.s = s; v.st = st; v.e_pick = ep;
    v.e_iv = eiv; v.e_idx0 = ei0; v.e_idx1 = ei1; v.e_cnt = ec; v.e_full = ef;
    tbl.push_back(v);
  endtask

  initial begin
    //   alloc    rel      ready    sel   stall pick     iv     idx0     idx1     cnt full
    // oldest-first across successive allocations 3,1,5
    add(16'h0008, 16'h0000, 16'h0000, SEL0, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 5'd1, 1'b0);
    add(16'h0002, 16'h0000, 16'h0000, SEL0, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 5'd2, 1'b0);
    add(16'h0020, 16'h0000, 16'h0000, SEL0, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 5'd3, 1'b0);
    add(16'h0000, 16'h0008, 16'h002A, SEL0, 2'b00, 16'h0008, 2'b01, 16'h0008, 16'h0000, 5'd2, 1'b0);
    add(16'h0000, 16'h0002, 16'h002A, SEL0, 2'b00, 16'h0002, 2'b01, 16'h0002, 16'h0000, 5'd1, 1'b0);
    add(16'h0000, 16'h0020, 16'h002A, SEL0, 2'b00, 16'h0020, 2'b01, 16'h0020, 16'h0000, 5'd0, 1'b0);
    // same-cycle allocation: lower index is older
    add(16'h0006, 16'h0000, 16'h0000, SEL0, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 5'd2, 1'b0);
    add(16'h0000, 16'h0002, 16'h0006, SEL0, 2'b00, 16'h0002, 2'b01, 16'h0002, 16'h0000, 5'd1, 1'b0);
    add(16'h0000, 16'h0004, 16'h0006, SEL0, 2'b00, 16'h0004, 2'b01, 16'h0004, 16'h0000, 5'd0, 1'b0);
    // dual-pipe pick in one cycle
    add(16'h0004, 16'h0000, 16'h0000, SELB, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 5'd1, 1'b0);
    add(16'h0010, 16'h0000, 16'h0000, SELB, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 5'd2, 1'b0);
    add(16'h0000, 16'h0000, 16'h0014, SELB, 2'b00, 16'h0014, 2'b11, 16'h0004, 16'h0010, 5'd2, 1'b0);
    add(16'h0000, 16'h0014, 16'h0000, SELB, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 5'd0, 1'b0);
    // stall on pipe 0 suppresses, then picks once it drops
    add(16'h0001, 16'h0000, 16'h0000, SEL0, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 5'd1, 1'b0);
    add(16'h0000, 16'h0000, 16'h0001, SEL0, 2'b01, 16'h0000, 2'b00, 16'h0000, 16'h0000, 5'd1, 1'b0);
    add(16'h0000, 16'h0001, 16'h0001, SEL0, 2'b00, 16'h0001, 2'b01, 16'h0001, 16'h0000, 5'd0, 1'b0);
    // full queue, release+alloc of entry 0 keeps count and makes it youngest
    add(16'hFFFF, 16'h0000, 16'h0000, SEL0, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 5'd16, 1'b1);
    add(16'h0001, 16'h0001, 16'h0000, SEL0, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 5'd16, 1'b1);
    add(16'h0000, 16'h0000, 16'h0003, SEL0, 2'b00, 16'h0002, 2'b01, 16'h0002, 16'h0000, 5'd16, 1'b1);
    add(16'h0000, 16'h0000, 16'h0001, SEL0, 2'b00, 16'h0001, 2'b01, 16'h0001, 16'h0000, 5'd16, 1'b1);
    add(16'h0000, 16'hFFFF, 16'h0000, SEL0, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 5'd0, 1'b0);

    i_reset_n = 1'b0;
    i_alloc_oh = '0; i_release_oh = '0; i_entry_ready = '0;
    i_entry_pipe_sel = '0; i_pipe_stall = '0;
    m_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_iv",   64'(o_issue_valid), 64'(0));
    chk("rst_idx",  64'(o_issue_idx_oh), 64'(0));
    chk("rst_cnt",  64'(o_valid_cnt), 64'(0));
    chk("rst_full", 64'(o_full), 64'(0));
    chk("rst_pick", 64'(o_entry_picked), 64'(0));
    i_reset_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      tick(tbl[k].a, tbl[k].r, tbl[k].rd, tbl[k].s, tbl[k].st);
      chk($sformatf("vec%0d_pick", k), 64'(last_pick), 64'(tbl[k].e_pick));
      chk($sformatf("vec%0d_iv", k),   64'(o_issue_valid), 64'(tbl[k].e_iv));
      chk($sformatf("vec%0d_idx", k),  64'(o_issue_idx_oh), 64'({tbl[k].e_idx1, tbl[k].e_idx0}));
      chk($sformatf("vec%0d_cnt", k),  64'(o_valid_cnt), 64'(tbl[k].e_cnt));
      chk($sformatf("vec%0d_full", k), 64'(o_full), 64'(tbl[k].e_full));
    end

    // reset while an issue is in flight
    tick(16'h0001, 16'h0000, 16'h0000, SEL0, 2'b00);
    tick(16'h0000, 16'h0000, 16'h0001, SEL0, 2'b00);
    chk("mid_iv_before", 64'(o_issue_valid), 64'(1));
    #2 i_reset_n = 1'b0;
    #1;
    m_reset();
    chk("mid_rst_iv",   64'(o_issue_valid), 64'(0));
    chk("mid_rst_idx",  64'(o_issue_idx_oh), 64'(0));
    chk("mid_rst_cnt",  64'(o_valid_cnt), 64'(0));
    chk("mid_rst_pick", 64'(o_entry_picked), 64'(0));
    chk("mid_rst_full", 64'(o_full), 64'(0));
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    tick(16'h0000, 16'h0000, 16'h0001, SEL0, 2'b00);
    chk("post_rst_iv",   64'(o_issue_valid), 64'(0));
    chk("post_rst_pick", 64'(last_pick), 64'(0));

    // constrained-random traffic
    for (int c = 0; c < 3000; c++) begin
      logic [L-1:0]   vm, r, a, rd;
      logic [L*P-1:0] s;
      logic [P-1:0]   st;
      vm = m_valid_mask();
      r  = L'($urandom & $urandom) & vm;
      a  = L'($urandom & $urandom) & (~vm | r);
      rd = L'($urandom);
      s  = (P*L)'({$urandom, $urandom});
      st = P'($urandom & $urandom);
      tick(a, r, rd, s, st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
